// File: rtl/alu_iterative_pkg.sv
// Shared types for the iterative ALU:
// op codes and control state encoding.
package alu_iterative_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_LT   = 4'd12,
    ALU_GE   = 4'd13,
    ALU_LTU  = 4'd14,
    ALU_GEU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_iter_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == ALU_SLL) |
           (op == ALU_SRL) |
           (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Issue/result handshake bundle of the
// iterative ALU (valid/ready in, valid/yumi out).
interface alu_iterative_if
  import alu_iterative_pkg::*;
#(
  parameter int width_p = 32
);
  logic               v_i;
  logic               ready_o;
  alu_op_e            op_i;
  logic [width_p-1:0] op1_i;
  logic [width_p-1:0] op2_i;
  logic               v_o;
  logic               yumi_i;
  logic [width_p-1:0] result_o;
  logic               busy_o;

  modport master (
    output v_i, op_i, op1_i, op2_i, yumi_i,
    input  ready_o, v_o, result_o, busy_o
  );

  modport slave (
    input  v_i, op_i, op1_i, op2_i, yumi_i,
    output ready_o, v_o, result_o, busy_o
  );
endinterface

// File: rtl/alu_iterative_shifter.sv
// Multi-cycle shifter: moves the stage by up
// to shift_step_p bits each cycle until done.
module alu_iterative_shifter
  import alu_iterative_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int shift_step_p = 4,
  localparam int aw = $clog2(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  alu_op_e            op_i,
  input  logic [aw-1:0]      amt_i,
  input  logic [width_p-1:0] data_i,
  output logic               done_o,
  output logic [width_p-1:0] data_o
);

  localparam int cw = aw + 1;
  localparam logic [cw-1:0] step_max =
    cw'(shift_step_p);

  logic [width_p-1:0]   stage;
  logic [cw-1:0]        rem;
  logic                 sign;
  logic                 left;
  logic                 active;
  logic [cw-1:0]        step;
  logic [2*width_p-1:0] ext;

  // Next stage value for this cycle's step.
  always_comb begin
    step = (rem < step_max) ? rem : step_max;
    ext  = {{width_p{sign}}, stage} >> step;
    if (left) data_o = stage << step;
    else      data_o = ext[width_p-1:0];
    done_o = active & (rem == step);
  end

  // Stage, remaining count and fill latch.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage  <= '0;
      rem    <= '0;
      sign   <= 1'b0;
      left   <= 1'b0;
      active <= 1'b0;
    end else if (start_i) begin
      stage  <= data_i;
      rem    <= {1'b0, amt_i};
      sign   <= (op_i == ALU_SRA) &
                data_i[width_p-1];
      left   <= (op_i == ALU_SLL);
      active <= (amt_i != '0);
    end else if (active) begin
      stage <= data_o;
      rem   <= rem - step;
      if (rem == step) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iterative.sv
// Handshaked integer ALU: one-cycle ops plus
// iterative shifts, result held until yumi.
module alu_iterative
  import alu_iterative_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int shift_step_p = 4
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  alu_iterative_if.slave  bus
);

  localparam int aw = $clog2(width_p);

  alu_iter_state_e    state;
  logic [width_p-1:0] result;
  logic [width_p-1:0] alu_res;
  logic [width_p-1:0] sh_data;
  logic [aw-1:0]      amt;
  logic               sh_done;
  logic               accept;
  logic               sh_start;
  logic [width_p-1:0] a;
  logic [width_p-1:0] b;
  logic               lts;
  logic               ltu;
  logic               eq;

  assign a   = bus.op1_i;
  assign b   = bus.op2_i;
  assign amt = b[aw-1:0];
  assign lts = $signed(a) < $signed(b);
  assign ltu = a < b;
  assign eq  = a == b;

  assign bus.ready_o =
    (state == ST_IDLE) |
    ((state == ST_DONE) & bus.yumi_i);
  assign accept   = bus.v_i & bus.ready_o;
  assign sh_start = accept &
                    is_shift(bus.op_i) &
                    (amt != '0);

  assign bus.v_o      = (state == ST_DONE);
  assign bus.busy_o   = (state == ST_SHIFT);
  assign bus.result_o = result;

  // Single-cycle result path.
  always_comb begin
    alu_res = a + b;
    case (bus.op_i)
      ALU_SUB:  alu_res = a - b;
      ALU_SLT:  alu_res = {{(width_p-1){1'b0}}, lts};
      ALU_SLTU: alu_res = {{(width_p-1){1'b0}}, ltu};
      ALU_XOR:  alu_res = a ^ b;
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_res = a;
      ALU_EQ:   alu_res = {{(width_p-1){1'b0}}, eq};
      ALU_NE:   alu_res = {{(width_p-1){1'b0}}, !eq};
      ALU_LT:   alu_res = {{(width_p-1){1'b0}}, lts};
      ALU_GE:   alu_res = {{(width_p-1){1'b0}}, !lts};
      ALU_LTU:  alu_res = {{(width_p-1){1'b0}}, ltu};
      ALU_GEU:  alu_res = {{(width_p-1){1'b0}}, !ltu};
      default:  alu_res = a + b;
    endcase
  end

  alu_iterative_shifter #(
    .width_p      (width_p),
    .shift_step_p (shift_step_p)
  ) shifter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (sh_start),
    .op_i      (bus.op_i),
    .amt_i     (amt),
    .data_i    (a),
    .done_o    (sh_done),
    .data_o    (sh_data)
  );

  // Control FSM and output result register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      result <= '0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (sh_done) begin
            result <= sh_data;
            state  <= ST_DONE;
          end
        end
        ST_IDLE,
        ST_DONE: begin
          if (accept) begin
            if (sh_start) begin
              state <= ST_SHIFT;
            end else begin
              result <= alu_res;
              state  <= ST_DONE;
            end
          end else if (state == ST_DONE &&
                       bus.yumi_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Protocol checks for the issuing side.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(bus.yumi_i && !bus.v_o))
        else $error("yumi_i without v_o");
      assert (!(bus.v_i &&
                $isunknown(bus.op_i)))
        else $error("illegal op_i");
    end
  end
`endif

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for
// alu_iterative (width 32, step 4).
module tb_alu_iterative;
  import alu_iterative_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  alu_iterative_if #(.width_p(32)) bus();

  alu_iterative #(
    .width_p      (32),
    .shift_step_p (4)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input  alu_op_e     op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] res,
    output int          lat,
    output int          busy_n,
    output logic        rdy_bad
  );
    bus.v_i    = 1'b1;
    bus.op_i   = op;
    bus.op1_i  = x;
    bus.op2_i  = y;
    bus.yumi_i = 1'b0;
    step_clk();
    bus.v_i = 1'b0;
    lat     = 1;
    busy_n  = 0;
    rdy_bad = 1'b0;
    while (!bus.v_o && lat < 60) begin
      if (bus.busy_o) busy_n++;
      if (bus.busy_o && bus.ready_o)
        rdy_bad = 1'b1;
      step_clk();
      lat++;
    end
    res = bus.result_o;
    if (bus.v_o) begin
      bus.yumi_i = 1'b1;
      step_clk();
      bus.yumi_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_total++;
    if (bus.v_o !== 1'b0)
      $display("FAIL rst_v_o got=%b exp=0", bus.v_o);
    else n_pass++;
    n_total++;
    if (bus.result_o !== 32'h0)
      $display("FAIL rst_result got=%h exp=0",
               bus.result_o);
    else n_pass++;
    n_total++;
    if (bus.busy_o !== 1'b0)
      $display("FAIL rst_busy got=%b exp=0", bus.busy_o);
    else n_pass++;
    n_total++;
    if (bus.ready_o !== 1'b1)
      $display("FAIL rst_ready got=%b exp=1",
               bus.ready_o);
    else n_pass++;
  endtask

  task automatic test_add_sub_stream();
    bus.v_i   = 1'b1;
    bus.op_i  = ALU_ADD;
    bus.op1_i = 32'h7FFF_FFFF;
    bus.op2_i = 32'h0000_0001;
    step_clk();
    n_total++;
    if (bus.v_o !== 1'b1 ||
        bus.result_o !== 32'h8000_0000)
      $display("FAIL add v=%b got=%h exp=80000000",
               bus.v_o, bus.result_o);
    else n_pass++;
    bus.yumi_i = 1'b1;
    bus.op_i   = ALU_SUB;
    bus.op1_i  = 32'h0;
    bus.op2_i  = 32'h1;
    #1;
    n_total++;
    if (bus.ready_o !== 1'b1)
      $display("FAIL stream_ready got=%b exp=1",
               bus.ready_o);
    else n_pass++;
    step_clk();
    n_total++;
    if (bus.v_o !== 1'b1 ||
        bus.result_o !== 32'hFFFF_FFFF)
      $display("FAIL sub v=%b got=%h exp=ffffffff",
               bus.v_o, bus.result_o);
    else n_pass++;
    bus.v_i = 1'b0;
    step_clk();
    bus.yumi_i = 1'b0;
    n_total++;
    if (bus.v_o !== 1'b0 || bus.ready_o !== 1'b1)
      $display("FAIL idle_after v=%b rdy=%b exp=0,1",
               bus.v_o, bus.ready_o);
    else n_pass++;
  endtask

  task automatic test_compare();
    alu_op_e     ops [12];
    logic [31:0] xa  [12];
    logic [31:0] ya  [12];
    logic [31:0] ex  [12];
    logic [31:0] r;
    int          lat;
    int          bn;
    logic        rb;
    ops = '{ALU_SLT, ALU_SLTU, ALU_GEU, ALU_NE,
            ALU_EQ, ALU_LT, ALU_GE, ALU_LTU,
            ALU_XOR, ALU_OR, ALU_AND, ALU_SUB};
    xa  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5,
            32'h5, 32'h5, 32'hFFFF_FFFE, 32'h3,
            32'h2, 32'hF0F0_0000, 32'h0000_00F0,
            32'hFF00_FF00, 32'h10};
    ya  = '{32'h1, 32'h1, 32'h5, 32'h5, 32'h5,
            32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFF00_0000, 32'h0000_000F,
            32'h0FF0_0FF0, 32'h3};
    ex  = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h1,
            32'h1, 32'h1, 32'h1, 32'h0FF0_0000,
            32'h0000_00FF, 32'h0F00_0F00, 32'hD};
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], xa[i], ya[i], r, lat, bn, rb);
      n_total++;
      if (r !== ex[i] || lat != 1)
        $display("FAIL cmp_%0d %s got=%h lat=%0d exp=%h lat=1",
                 i, ops[i].name(), r, lat, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_shift();
    alu_op_e     ops [5];
    logic [31:0] xa  [5];
    logic [31:0] ya  [5];
    logic [31:0] ex  [5];
    int          el  [5];
    logic [31:0] r;
    int          lat;
    int          bn;
    logic        rb;
    ops = '{ALU_SRA, ALU_SRL, ALU_SLL,
            ALU_SRA, ALU_SRL};
    xa  = '{32'h8000_0000, 32'h8000_0000, 32'h1,
            32'h8000_0000, 32'h0000_F000};
    ya  = '{32'd31, 32'd31, 32'h25, 32'd4, 32'd7};
    ex  = '{32'hFFFF_FFFF, 32'h1, 32'h20,
            32'hF800_0000, 32'h0000_01E0};
    el  = '{9, 9, 3, 2, 3};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], xa[i], ya[i], r, lat, bn, rb);
      n_total++;
      if (r !== ex[i] || lat != el[i])
        $display("FAIL shift_%0d %s got=%h lat=%0d exp=%h lat=%0d",
                 i, ops[i].name(), r, lat, ex[i], el[i]);
      else n_pass++;
      n_total++;
      if (bn != el[i] - 1 || rb)
        $display("FAIL shift_busy_%0d busy=%0d rdy_bad=%b exp=%0d,0",
                 i, bn, rb, el[i] - 1);
      else n_pass++;
    end
  endtask

  task automatic test_shift_zero();
    logic [31:0] r;
    int          lat;
    int          bn;
    logic        rb;
    run_op(ALU_SLL, 32'h1234, 32'h0,
           r, lat, bn, rb);
    n_total++;
    if (r !== 32'h1234 || lat != 1 || bn != 0)
      $display("FAIL shift_zero got=%h lat=%0d busy=%0d exp=1234,1,0",
               r, lat, bn);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic bad;
    bus.v_i    = 1'b1;
    bus.op_i   = ALU_ADD;
    bus.op1_i  = 32'd10;
    bus.op2_i  = 32'd20;
    bus.yumi_i = 1'b0;
    step_clk();
    bus.v_i = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.v_o !== 1'b1 ||
          bus.result_o !== 32'd30 ||
          bus.ready_o !== 1'b0)
        bad = 1'b1;
      step_clk();
    end
    n_total++;
    if (bad)
      $display("FAIL hold got v=%b r=%h rdy=%b exp=1,1e,0",
               bus.v_o, bus.result_o, bus.ready_o);
    else n_pass++;
    bus.v_i    = 1'b1;
    bus.op1_i  = 32'd2;
    bus.op2_i  = 32'd3;
    bus.yumi_i = 1'b1;
    #1;
    n_total++;
    if (bus.ready_o !== 1'b1)
      $display("FAIL bp_ready got=%b exp=1",
               bus.ready_o);
    else n_pass++;
    step_clk();
    bus.v_i    = 1'b0;
    bus.yumi_i = 1'b0;
    n_total++;
    if (bus.v_o !== 1'b1 || bus.result_o !== 32'd5)
      $display("FAIL bp_next v=%b got=%h exp=5",
               bus.v_o, bus.result_o);
    else n_pass++;
    bus.yumi_i = 1'b1;
    step_clk();
    bus.yumi_i = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic stale;
    bus.v_i   = 1'b1;
    bus.op_i  = ALU_SRA;
    bus.op1_i = 32'h8000_0000;
    bus.op2_i = 32'd31;
    step_clk();
    bus.v_i = 1'b0;
    step_clk();
    step_clk();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.v_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.result_o !== 32'h0)
      $display("FAIL mid_rst v=%b busy=%b r=%h exp=0,0,0",
               bus.v_o, bus.busy_o, bus.result_o);
    else n_pass++;
    #3;
    rst_n = 1'b1;
    step_clk();
    n_total++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0)
      $display("FAIL post_rst rdy=%b busy=%b exp=1,0",
               bus.ready_o, bus.busy_o);
    else n_pass++;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.v_o !== 1'b0) stale = 1'b1;
      step_clk();
    end
    n_total++;
    if (stale)
      $display("FAIL stale_result v=%b r=%h exp=0",
               bus.v_o, bus.result_o);
    else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst_n      = 1'b0;
    bus.v_i    = 1'b0;
    bus.op_i   = ALU_ADD;
    bus.op1_i  = '0;
    bus.op2_i  = '0;
    bus.yumi_i = 1'b0;
    #12;
    rst_n = 1'b1;
    step_clk();
    test_reset();
    test_add_sub_stream();
    test_compare();
    test_shift();
    test_shift_zero();
    test_backpressure();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Parametrised, handshaked integer ALU for vanilla-core and accelerator datapaths.
- Width is generic (width_p); `rs1`/`rs2` style operands arrive together with a packed op code.
- Logic, add/sub, compare and branch-condition ops complete in one cycle.
- Shifts run iteratively, shift_step_p bits per cycle, which trades latency for area on wide configurations.
- Results are held in an output register until consumed (valid/yumi).

Parameters:
- width_p, 32, operand/result width; power of 2, >= 8.
- shift_step_p, 4, max bit positions shifted per cycle; power of 2, 1..width_p.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- v_i  in  1  operation valid
- ready_o  out  1  block can accept an operation this cycle
- op_i  in  4  alu_op_e operation code
- op1_i  in  width_p  first operand
- op2_i  in  width_p  second operand (register value or pre-extended immediate)
- v_o  out  1  result valid
- yumi_i  in  1  consumer takes result; legal only when v_o=1
- result_o  out  width_p  result
- busy_o  out  1  iterative shift in progress

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - state=IDLE; v_o=0, result_o=0, busy_o=0.
  - Shift counter and staging registers cleared.
  - ready_o=1 once reset deasserts.
  - Reset mid-shift aborts the operation with no output.
- States: IDLE, SHIFT, DONE.
- Accept condition: v_i & ready_o.
- ready_o = (state==IDLE) | (state==DONE & yumi_i); this permits back-to-back issue in the cycle the old result is taken.
- Non-shift op accepted:
  - Result computed combinationally and registered; state -> DONE; v_o=1 the next cycle (latency 1).
- Op semantics:
  - ADD/SUB: modulo 2^width_p.
  - SLT/SLTU: signed/unsigned op1<op2 -> {0..,1}.
  - XOR/OR/AND: bitwise.
  - EQ/NE/LT/GE/LTU/GEU: branch condition in result_o[0], upper bits 0.
- Shift op accepted (SLL/SRL/SRA):
  - amt = op2_i[log2(width_p)-1:0]; upper op2 bits are ignored.
  - Stage = op1_i; remaining = amt; sign bit latched for SRA.
  - amt==0: state -> DONE, result=op1_i, latency 1.
  - Otherwise state -> SHIFT, busy_o=1.
  - Each SHIFT cycle shifts the stage by min(shift_step_p, remaining) and decrements remaining by the same.
  - SRL fills with 0; SRA fills with the latched sign; SLL fills with 0.
  - When remaining reaches 0 the result is registered and state -> DONE.
  - Total latency from accept to v_o = 1 + ceil(amt/shift_step_p).
- DONE:
  - v_o=1; result_o stable until yumi_i.
  - yumi_i & !v_i: -> IDLE.
  - yumi_i & v_i: the new op is accepted in the same cycle and follows the non-shift/shift rules above.
  - !yumi_i: hold; ready_o=0.
- Unused op codes: behave as ADD. A simulation-only assertion flags the illegal code.
- Simulation-only assertion: yumi_i while v_o=0.
- In IDLE/DONE, v_i with an unknown op_i must never change state.

Decomposition:
- bsg_vanilla_pkg gains:
  - typedef enum logic [3:0] alu_op_e: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NE, LT, GE, LTU, GEU.
  - typedef enum logic [1:0] alu_iter_state_e.
- One sub-module, alu_iterative_shifter: owns the stage register, remaining counter and sign latch.
  - Interface: start/op/amt/data in; done/data out.
- The single-cycle result path stays in the top module.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 with yumi_i tied high -> v_o the next cycle, result 0x80000000; SUB 0x0-0x1 -> 0xFFFFFFFF.
- SLT 0xFFFFFFFF,0x1 -> 1; SLTU same operands -> 0; GEU 0x5,0x5 -> 0x00000001; NE 0x5,0x5 -> 0.
- SRA 0x80000000 by 31 (width_p=32, shift_step_p=4) -> busy_o and ready_o=0 for 8 cycles, v_o on cycle 9, result 0xFFFFFFFF. SRL same operands -> 0x00000001. SLL 0x1 by op2=0x25 (amt 5) -> 0x20 after 3 cycles.
- SLL 0x1234 by 0 -> latency 1, result 0x1234, busy_o never asserted.
- Backpressure: hold yumi_i=0 for 5 cycles -> result_o/v_o stable, ready_o=0. Then yumi_i=1 with v_i=1 (ADD 2+3) -> accepted the same cycle, result 5 next cycle.
- Reset mid-shift: assert reset_n_i=0 asynchronously on cycle 3 of a 31-bit SRA -> v_o, busy_o, result_o go 0 immediately, state IDLE after release, no stale result ever appears.
